// File: rtl/m2vcoefpack.sv
// Coefficient packer: pulls 64 dequantized coefficients column-major and presents
// them as 8 packed columns through two ping-pong slots. Option: M2VCOEFPACK_COLZERO_EN.
module m2vcoefpack #(
  parameter int COEF_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  softreset,
  output logic                  ready_pack,
  input  logic                  blk_start,
  input  logic                  coef_sign,
  input  logic [COEF_W-1:0]     coef_data,
  output logic                  coef_next,
  output logic                  col_valid,
  input  logic                  col_ready,
  output logic [8*COEF_W-1:0]   col_data,
  output logic [2:0]            col_idx,
  output logic                  col_last,
  output logic                  col_zero
);

  typedef enum logic [1:0] {S_IDLE, S_PULL, S_DRAIN} state_t;

  state_t            state_q, state_d;
  logic [5:0]        pull_cnt_q, pull_cnt_d;
  logic              fl_vld_q, fl_vld_d;
  logic [2:0]        fl_row_q, fl_row_d;
  logic              fl_slot_q, fl_slot_d;
  logic [1:0]        full_q, full_d;
  logic [2:0]        col_idx_q, col_idx_d;
  logic [COEF_W-1:0] slot_q [2][8];
  logic [COEF_W-1:0] slot_d [2][8];

  logic flush;
  logic rd_slot;
  logic tgt_slot;
  logic pop;
  logic unused_sign;

  // The sign arrives separately for other consumers; data already carries it.
  assign unused_sign = coef_sign;

  assign flush     = reset | softreset;
  assign rd_slot   = col_idx_q[0];
  assign tgt_slot  = pull_cnt_q[3];
  assign col_valid = full_q[rd_slot] & ~flush;
  assign pop       = col_valid & col_ready;
  assign col_idx   = col_idx_q;
  assign col_last  = col_valid & (col_idx_q == 3'd7);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (flush) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (blk_start) state_d = S_PULL;
      S_PULL:  if (coef_next && pull_cnt_q == 6'd63) state_d = S_DRAIN;
      S_DRAIN: if (pop && col_idx_q == 3'd7) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs; a pull may reuse the slot that is being popped this cycle
  always_comb begin
    ready_pack = (state_q == S_IDLE);
    coef_next  = 1'b0;
    if (state_q == S_PULL && !flush)
      coef_next = ~full_q[tgt_slot] | (pop & (rd_slot == tgt_slot));
  end

  always_comb begin
    pull_cnt_d = pull_cnt_q;
    col_idx_d  = col_idx_q;
    full_d     = full_q;
    slot_d     = slot_q;
    fl_vld_d   = coef_next;
    fl_row_d   = pull_cnt_q[2:0];
    fl_slot_d  = tgt_slot;
    if (coef_next) pull_cnt_d = pull_cnt_q + 6'd1;
    if (pop) begin
      full_d[rd_slot] = 1'b0;
      col_idx_d       = col_idx_q + 3'd1;
    end
    if (fl_vld_q) begin
      slot_d[fl_slot_q][fl_row_q] = coef_data;
      if (fl_row_q == 3'd7) full_d[fl_slot_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      pull_cnt_q <= '0;
      col_idx_q  <= '0;
      full_q     <= '0;
      fl_vld_q   <= 1'b0;
      fl_row_q   <= '0;
      fl_slot_q  <= 1'b0;
    end else begin
      pull_cnt_q <= pull_cnt_d;
      col_idx_q  <= col_idx_d;
      full_q     <= full_d;
      fl_vld_q   <= fl_vld_d;
      fl_row_q   <= fl_row_d;
      fl_slot_q  <= fl_slot_d;
    end
  end

  // Slot payload needs no reset: it is only visible while the slot is full.
  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pack
      assign col_data[gi*COEF_W +: COEF_W] = col_valid ? slot_q[rd_slot][gi] : '0;
    end
  endgenerate

`ifdef M2VCOEFPACK_COLZERO_EN
  logic [1:0] zero_q, zero_d;

  // Running NOR, restarted by row 0 of each column.
  always_comb begin
    zero_d = zero_q;
    if (fl_vld_q) begin
      if (fl_row_q == 3'd0) zero_d[fl_slot_q] = (coef_data == '0);
      else                  zero_d[fl_slot_q] = zero_q[fl_slot_q] & (coef_data == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (flush) zero_q <= '0;
    else       zero_q <= zero_d;
  end

  assign col_zero = col_valid & zero_q[rd_slot];
`else
  assign col_zero = 1'b0;
`endif

endmodule
